nibble_add_scheduler: RTL and testbench

Shares one 4-bit full-adder slice (ripple of four 1-bit full adders: s = a^b^cin, cout = ab|a·cin|b·cin) between two requesters. Each request carries a WIDTH-bit add.
The scheduler arbitrates round-robin, then sequences the slice one nibble per cycle, LSB nibble first, with a registered carry between nibbles. It returns sum, carry-out and requester id on a valid/ready response channel.
It sits between the operand sources and the result consumer wherever a full-width adder is too costly.

---
 rtl/nibble_add_scheduler.sv | 133 +++++++++++++
 tb/tb_nibble_add_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_scheduler.sv
// nibble_add_scheduler: two requesters share one 4-bit ripple adder slice.
// A WIDTH-bit add is granted round-robin, then walked LSB nibble first, one
// nibble per cycle, with the carry held in a flop between nibbles. The result
// is offered on a valid/ready response channel together with the requester id.

// One bit of the shared slice.
module nas_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module nibble_add_scheduler #(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);
  localparam int NNIB = WIDTH / NIB;
  localparam int IW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last_grant;   // 1 -> requester 0 wins the next tie
  logic             grant0, grant1, accept, last_nib;
  logic [NIB-1:0]   na, nb, ns;
  logic [NIB:0]     cch;

  // Round-robin grant; only offered in IDLE and never while reset is held.
  assign grant0 = !rst && (state == IDLE) && req0_valid && (!req1_valid ||  last_grant);
  assign grant1 = !rst && (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  assign accept = grant0 | grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);
  assign last_nib   = (idx == IW'(NNIB - 1));

  // Current nibble presented to the shared slice.
  assign na     = a_q[idx*NIB +: NIB];
  assign nb     = b_q[idx*NIB +: NIB];
  assign cch[0] = carry;

  for (genvar g = 0; g < NIB; g++) begin : g_fa
    nas_fa u_fa (
      .a  (na[g]),
      .b  (nb[g]),
      .ci (cch[g]),
      .s  (ns[g]),
      .co (cch[g+1])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: accept -> walk all nibbles -> hold result until taken.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last_nib)  state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Operand capture, nibble sequencing and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q        <= grant1 ? req1_a   : req0_a;
          b_q        <= grant1 ? req1_b   : req0_b;
          carry      <= grant1 ? req1_cin : req0_cin;
          idx        <= '0;
          last_grant <= grant1;
          rsp_id     <= grant1;
        end
        RUN: begin
          rsp_sum[idx*NIB +: NIB] <= ns;
          carry                   <= cch[NIB];
          idx                     <= idx + 1'b1;
          if (last_nib) begin
            rsp_cout  <= cch[NIB];
            rsp_valid <= 1'b1;
          end
        end
        DONE: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_scheduler.sv
// Bench for nibble_add_scheduler: reset values, directed vector table,
// round-robin from reset, response stall, mid-RUN reset, and a random
// two-requester run checked against a queue-based arithmetic model.
module tb_nibble_add_scheduler;
  localparam int W    = 16;
  localparam int NNIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
  logic [W-1:0] rsp_sum;

  nibble_add_scheduler #(.WIDTH(W), .NIB(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model / scoreboard ----------------
  typedef struct { logic [W-1:0] sum; logic cout; logic id; } exp_t;
  exp_t     q[$];
  logic     last_gid = 1'b1;
  bit       log_en = 0;
  int       acc_id[$];
  longint   acc_t[$];

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic id);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.id   = id;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      last_gid = 1'b1;
    end else begin
      if (req0_valid && req1_valid) begin
        chk("one_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (req0_ready | req1_ready)
          chk("round_robin", {31'd0, req1_ready}, {31'd0, ~last_gid});
      end
      if (req0_valid && req0_ready) begin
        q.push_back(model(req0_a, req0_b, req0_cin, 1'b0));
        last_gid = 1'b0;
        if (log_en) begin acc_id.push_back(0); acc_t.push_back($time); end
      end else if (req1_valid && req1_ready) begin
        q.push_back(model(req1_a, req1_b, req1_cin, 1'b1));
        last_gid = 1'b1;
        if (log_en) begin acc_id.push_back(1); acc_t.push_back($time); end
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_sum",  {16'd0, rsp_sum},       {16'd0, e.sum});
          chk("sb_cout", {31'd0, rsp_cout},      {31'd0, e.cout});
          chk("sb_id",   {31'd0, rsp_id},        {31'd0, e.id});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int r, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
    if (r == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; end
  endtask

  // Hold valid until granted (bounded); returns at accept edge + 1.
  task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output bit ok);
    int k;
    ok = 0;
    set_req(r, 1'b1, a, b, cin);
    for (k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = (r == 0) ? req0_ready : req1_ready;
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
    else begin @(posedge clk); #1; end
    set_req(r, 1'b0, a, b, cin);
  endtask

  typedef struct {
    logic id; logic [W-1:0] a; logic [W-1:0] b; logic cin;
    logic [W-1:0] sum; logic cout;
  } vec_t;
  vec_t tbl[7];

  task automatic do_op(input vec_t v);
    bit ok;
    issue(int'(v.id), v.a, v.b, v.cin, ok);
    if (!ok) return;
    repeat (NNIB - 1) @(posedge clk);
    #1;
    chk("early_valid", {31'd0, rsp_valid}, 32'd0);
    chk("busy_run",    {31'd0, busy},      32'd1);
    @(posedge clk); #1;
    chk("rsp_valid",   {31'd0, rsp_valid}, 32'd1);
    chk("vec_sum",     {16'd0, rsp_sum},   {16'd0, v.sum});
    chk("vec_cout",    {31'd0, rsp_cout},  {31'd0, v.cout});
    chk("vec_id",      {31'd0, rsp_id},    {31'd0, v.id});
    chk("busy_done",   {31'd0, busy},      32'd1);
    @(posedge clk); #1;
    chk("busy_after",  {31'd0, busy},      32'd0);
    chk("valid_after", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic drv(input int r, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(r, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), ok);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400 && (q.size() != 0 || rsp_valid); k++) @(posedge clk);
    #1;
    chk("drained", q.size(), 32'd0);
  endtask

  bit rnd_done = 0;

  initial begin
    bit ok;
    int k;
    tbl[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    tbl[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{1'b1, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    tbl[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[4] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[5] = '{1'b0, 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0};
    tbl[6] = '{1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};

    // Reset with both requesters already asking.
    rst = 1'b1; rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    set_req(1, 1'b1, 16'h0F0F, 16'h00F1, 1'b1);
    #12;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_sum",   {16'd0, rsp_sum},   32'd0);
    chk("rst_cout",  {31'd0, rsp_cout},  32'd0);
    chk("rst_id",    {31'd0, rsp_id},    32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_rdy0",  {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1",  {31'd0, req1_ready}, 32'd0);

    // Round-robin from reset with both held valid.
    log_en = 1;
    @(posedge clk); #1; rst = 1'b0;
    for (k = 0; k < 100 && acc_id.size() < 4; k++) @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h1111, 16'h2222, 1'b0);
    set_req(1, 1'b0, 16'h0F0F, 16'h00F1, 1'b1);
    log_en = 0;
    chk("rr_count", acc_id.size(), 32'd4);
    if (acc_id.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", acc_id[i], i % 2);
      for (int i = 0; i < 3; i++) chk("rr_spacing", 32'(acc_t[i+1] - acc_t[i]), 32'd60);
    end
    drain();

    // Directed vector table.
    for (int i = 0; i < 7; i++) do_op(tbl[i]);

    // Response stall: result held, no grants, late operand changes ignored.
    rsp_ready = 1'b0;
    issue(0, 16'hABCD, 16'h1234, 1'b1, ok);
    for (k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      set_req(0, 1'b1, W'($urandom), W'($urandom), 1'b1);
      set_req(1, 1'b1, W'($urandom), W'($urandom), 1'b0);
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid},  32'd1);
      chk("stall_sum",   {16'd0, rsp_sum},    32'h0000BE02);
      chk("stall_cout",  {31'd0, rsp_cout},   32'd0);
      chk("stall_id",    {31'd0, rsp_id},     32'd0);
      chk("stall_rdy0",  {31'd0, req0_ready}, 32'd0);
      chk("stall_rdy1",  {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {31'd0, rsp_valid}, 32'd0);

    // Reset after two nibbles of a RUN.
    issue(0, 16'h5555, 16'h5555, 1'b0, ok);
    @(posedge clk); @(posedge clk); #1;
    req0_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, rsp_valid},  32'd0);
    chk("midrst_busy",  {31'd0, busy},       32'd0);
    chk("midrst_rdy0",  {31'd0, req0_ready}, 32'd0);
    #12;
    req0_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op('{1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0});

    // Random traffic on both requesters with random response stalls.
    fork
      begin
        fork
          drv(0, 500);
          drv(1, 500);
        join
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
